// File: rtl/sram_1w1r_sync.sv
// sram_1w1r_sync: single-clock 1W/1R SRAM model with byte mask,
// write-first forwarding, read-valid strobe and optional clear FSM.
module sram_1w1r_sync #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int NUM_WMASKS     = DATA_WIDTH / 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_WMASKS != DATA_WIDTH / 8) begin : g_bad_mask
    $error("NUM_WMASKS is derived and must not be overridden");
  end

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clr_we;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;

  assign clr_we = !rst && (state == CLEAR);
  assign wr_en  = !rst && (state == READY) && !csb0;
  assign rd_en  = !rst && (state == READY) && !csb1;

  // busy also covers the reset cycles so nothing sneaks in before CLEAR
  assign init_busy = (state == CLEAR) ||
                     (rst && (CLEAR_ON_RESET != 0));

  // clear sequencer: walk every address once, then park in READY
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1))
        state <= READY;
    end
  end

  // storage write port: clear fill has priority, else masked user write
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= CLEAR_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i])
          mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // read word with write-first merge of same-cycle masked write bytes
  always_comb begin
    rd_word = mem[addr1];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wr_en && (addr0 == addr1) && wmask0[i])
        rd_word[8*i +: 8] = din0[8*i +: 8];
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // single stage: capture word straight into the output register
    always_ff @(posedge clk) begin
      if (rst) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        dout1_valid <= rd_en;
        if (rd_en)
          dout1 <= rd_word;
      end
    end
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] p_data;
    logic                  p_valid;

    // two stages: array capture, then output register
    always_ff @(posedge clk) begin
      if (rst) begin
        p_data      <= '0;
        p_valid     <= 1'b0;
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        p_valid     <= rd_en;
        if (rd_en)
          p_data <= rd_word;
        dout1_valid <= p_valid;
        if (p_valid)
          dout1 <= p_data;
      end
    end
  end else begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_sram_1w1r_sync.sv
// tb_sram_1w1r_sync: directed checks of clear, byte mask, collision,
// latency-2 pipelining and reset during clear.
module tb_sram_1w1r_sync;

  logic        clk = 1'b0;
  logic        rst;

  logic        csb0_a, csb1_a;
  logic [3:0]  wmask0_a, addr0_a, addr1_a;
  logic [31:0] din0_a, dout1_a;
  logic        valid_a, busy_a;

  logic        csb0_b, csb1_b;
  logic [3:0]  wmask0_b, addr0_b, addr1_b;
  logic [31:0] din0_b, dout1_b;
  logic        valid_b, busy_b;

  int total = 0;
  int bad   = 0;
  int n;
  logic sv;

  always #5 clk = ~clk;

  sram_1w1r_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .csb0(csb0_a), .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a),
    .csb1(csb1_a), .addr1(addr1_a),
    .dout1(dout1_a), .dout1_valid(valid_a), .init_busy(busy_a)
  );

  sram_1w1r_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .csb0(csb0_b), .wmask0(wmask0_b), .addr0(addr0_b), .din0(din0_b),
    .csb1(csb1_b), .addr1(addr1_b),
    .dout1(dout1_b), .dout1_valid(valid_b), .init_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic busy_len(output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (busy_a && cnt < 40) begin
      step();
      cnt++;
      seen = seen | valid_a;
    end
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    csb0_a = 1'b0; addr0_a = a; din0_a = d; wmask0_a = m;
    step();
    csb0_a = 1'b1;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a,
                      input logic [31:0] exp);
    csb1_a = 1'b0; addr1_a = a;
    step();
    csb1_a = 1'b1;
    chk({tag, "_v"}, 32'(valid_a), 32'd1);
    chk({tag, "_d"}, dout1_a, exp);
    step();
    chk({tag, "_v0"}, 32'(valid_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    csb0_a = 1'b1; csb1_a = 1'b1; wmask0_a = '0;
    addr0_a = '0; addr1_a = '0; din0_a = '0;
    csb0_b = 1'b1; csb1_b = 1'b1; wmask0_b = '0;
    addr0_b = '0; addr1_b = '0; din0_b = '0;
    step();
    step();
    chk("rst_dout", dout1_a, 32'h0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_valid_b", 32'(valid_b), 32'd0);

    // accesses while clearing must be dropped
    rst = 1'b0;
    csb0_a = 1'b0; addr0_a = 4'd2; din0_a = 32'hFFFFFFFF;
    wmask0_a = 4'hF;
    csb1_a = 1'b0; addr1_a = 4'd2;
    busy_len(n, sv);
    csb0_a = 1'b1; csb1_a = 1'b1;
    chk("clr_len", 32'(n), 32'd16);
    chk("clr_novalid", 32'(sv), 32'd0);
    chk("clr_busy_b", 32'(busy_b), 32'd0);

    rd_a("clr9", 4'd9, 32'hA5A5A5A5);
    rd_a("clr2", 4'd2, 32'hA5A5A5A5);

    wr_a(4'd3, 32'hAABBCCDD, 4'b1111);
    wr_a(4'd3, 32'h11223344, 4'b0101);
    rd_a("mask", 4'd3, 32'hAA22CC44);
    wr_a(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd_a("mask0", 4'd3, 32'hAA22CC44);

    // same-address collision returns merged word
    wr_a(4'd7, 32'h0, 4'b1111);
    csb0_a = 1'b0; addr0_a = 4'd7; din0_a = 32'hDEADBEEF;
    wmask0_a = 4'b0011;
    csb1_a = 1'b0; addr1_a = 4'd7;
    step();
    csb0_a = 1'b1; csb1_a = 1'b1;
    chk("col_v", 32'(valid_a), 32'd1);
    chk("col_d", dout1_a, 32'h0000BEEF);
    step();
    chk("col_v0", 32'(valid_a), 32'd0);
    rd_a("col_mem", 4'd7, 32'h0000BEEF);

    // different addresses do not interact
    csb0_a = 1'b0; addr0_a = 4'd5; din0_a = 32'h12345678;
    wmask0_a = 4'hF;
    csb1_a = 1'b0; addr1_a = 4'd9;
    step();
    csb0_a = 1'b1; csb1_a = 1'b1;
    chk("ind_d", dout1_a, 32'hA5A5A5A5);
    step();
    rd_a("ind5", 4'd5, 32'h12345678);
    step();
    step();
    chk("hold_d", dout1_a, 32'h12345678);
    chk("hold_v", 32'(valid_a), 32'd0);

    // latency-2 instance: three back-to-back reads
    for (int i = 1; i <= 3; i++) begin
      csb0_b = 1'b0; addr0_b = 4'(i); din0_b = 32'(i);
      wmask0_b = 4'hF;
      step();
    end
    csb0_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      csb1_b = 1'b0; addr1_b = 4'(i);
      step();
      if (i == 1) begin
        chk("l2_v_first", 32'(valid_b), 32'd0);
      end else begin
        chk("l2_v", 32'(valid_b), 32'd1);
        chk("l2_d", dout1_b, 32'(i - 1));
      end
    end
    csb1_b = 1'b1;
    step();
    chk("l2_v3", 32'(valid_b), 32'd1);
    chk("l2_d3", dout1_b, 32'd3);
    step();
    chk("l2_vend", 32'(valid_b), 32'd0);

    // reset in the middle of a clear replays the whole clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    csb1_a = 1'b0; addr1_a = 4'd2;
    step();
    chk("mid_rst_d", dout1_a, 32'h0);
    chk("mid_rst_v", 32'(valid_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd1);
    step();
    chk("mid_rst_v2", 32'(valid_a), 32'd0);
    rst = 1'b0;
    busy_len(n, sv);
    csb1_a = 1'b1;
    chk("mid_len", 32'(n), 32'd16);
    chk("mid_novalid", 32'(sv), 32'd0);
    rd_a("mid3", 4'd3, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
